obstacle_lane_bank: RTL
=======================

// Module: obstacle_lane_bank
// PURPOSE
// - Generalised successor to the single-lane vertical mover. Holds NUM_LANES obstacle positions
//   (crocs, logs, cars) and advances them once per frame tick.
// - Each lane has its own speed, direction and mode (BOUNCE or WRAP). Bounds are exact; no overshoot.
// - Sits between the game-control FSM (config writes, pause) and the VGA sprite renderer (reads pos_flat).
// PARAMETERS
// NUM_LANES  4    number of independent lanes (1..16)
// POS_W      10   position width, bits
// SPEED_W    4    speed width, bits (pixels per tick)
// MIN_POS    16   lower bound, inclusive
// MAX_POS    400  upper bound, inclusive; MAX_POS > MIN_POS, both < 2**POS_W
// PORTS
// clk        in   1                  system clock
// rst        in   1                  synchronous, active-high reset
// tick       in   1                  frame strobe, 1-cycle pulse
// pause      in   1                  1 = ticks ignored (not queued)
// cfg_we     in   1                  config write strobe
// cfg_lane   in   clog2(NUM_LANES)   lane index for write
// cfg_pos    in   POS_W              new position (clamped to [MIN_POS,MAX_POS])
// cfg_speed  in   SPEED_W            new speed
// cfg_dir    in   1                  0 = increasing, 1 = decreasing
// cfg_mode   in   1                  0 = BOUNCE, 1 = WRAP
// pos_flat   out  NUM_LANES*POS_W    lane i at [i*POS_W +: POS_W]
// dir_flat   out  NUM_LANES          current direction per lane
// edge_evt   out  NUM_LANES          1-cycle pulse when a lane reverses or wraps
// busy       out  1                  update sweep in progress
// done       out  1                  1-cycle pulse, last lane written
// overrun    out  1                  sticky; a tick arrived while busy with one already pending
// BEHAVIOUR
// - One clock (clk). Reset is synchronous, active-high.
// - Reset values: every pos = MIN_POS, dir = 0, speed = 0, mode = BOUNCE. edge_evt, busy, done
//   and overrun = 0. FSM = IDLE.
// - Reset mid-sweep aborts the sweep. The pending tick is cleared.
// - FSM states:
//   - IDLE: tick & !pause -> SWEEP, lane index = 0.
//   - SWEEP: update lane[idx], idx++. At idx = NUM_LANES-1, assert done and go to IDLE,
//     or to SWEEP with idx = 0 if a tick is pending. busy = (state == SWEEP).
// - Timing: a tick in cycle T updates lane i at the edge ending cycle T+1+i. done is high in
//   cycle T+NUM_LANES.
// - Tick while busy:
//   - First one sets the 1-deep pending flag.
//   - A further tick while the flag is set sets overrun. overrun clears only on rst.
// - Step arithmetic uses POS_W+2 bits, signed: n = pos +/- speed.
//   - BOUNCE, dir 0, n > MAX_POS: pos = MAX_POS, dir = 1, edge_evt.
//   - BOUNCE, dir 1, n < MIN_POS: pos = MIN_POS, dir = 0, edge_evt.
//   - WRAP, dir 0, n > MAX_POS: pos = MIN_POS + (n - MAX_POS - 1), edge_evt, dir kept.
//   - WRAP, dir 1, n < MIN_POS: pos = MAX_POS - (MIN_POS - n - 1), edge_evt, dir kept.
//   - Landing exactly on a bound is not an event.
//   - speed = 0: no motion, no event.
//   - Speed > (MAX_POS - MIN_POS) is illegal configuration. Clamp the result to the bounds.
// - Config writes:
//   - Accepted in any state. All fields of cfg_lane update on the next edge.
//   - Same-cycle collision with a sweep step on that lane: config wins, the step is discarded,
//     no event.
// - pause does not stop an in-progress sweep.
// STRUCTURE
// - Header obstacle_defs.vh: MODE_BOUNCE/MODE_WRAP, FSM state encodings (IDLE, SWEEP).
// - Sub-module lane_step: combinational pos/speed/dir/mode -> next pos, next dir, evt.
//   Shared by all lanes through the sweep mux, so one adder in total.
// - Lane state is held in per-lane register arrays.
// TESTING
// - Reset: rst for 2 cycles. Expect all pos = 16, dir = 0, busy = 0, overrun = 0.
//   tick with speed 0 -> positions unchanged.
// - Bounce top: lane0 pos = 398, speed 5, dir 0, BOUNCE, tick. Expect pos = 400, dir = 1,
//   edge_evt[0] in cycle T+1. Next tick: pos = 395.
// - Wrap bottom: lane1 pos = 18, speed 5, dir 1, WRAP, tick. Expect pos = 398, dir = 1,
//   edge_evt[1]. Exact landing: pos = 21 -> 16, no event.
// - Timing (NUM_LANES = 4): tick at T. Lanes update at T+1..T+4, done at T+4. Tick at T+2 ->
//   second sweep begins T+5. Third tick at T+3 -> overrun = 1.
// - Collision: cfg_we to lane2 (pos 100) in the cycle its step is applied -> pos = 100,
//   no edge_evt[2]. cfg_pos = 900 -> 400.
// - Pause/reset: pause = 1 with tick -> no busy. rst asserted at T+2 of a sweep -> lanes at
//   reset values next cycle, done never pulses.

Source files
------------

// File: rtl/obstacle_lane_bank_pkg.sv
// Shared types and helpers for the obstacle lane bank.
package obstacle_lane_bank_pkg;

    // Lane motion mode: reverse at a bound, or reappear at the opposite bound.
    typedef enum logic {
        MODE_BOUNCE = 1'b0,
        MODE_WRAP   = 1'b1
    } lane_mode_t;

    // Sweep sequencer states.
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    // Clamp a value into [lo, hi]; used on configured positions.
    function automatic int unsigned clamp_range(input int unsigned v,
                                                input int unsigned lo,
                                                input int unsigned hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/obstacle_lane_bank_lane_step.sv
// Single-lane motion step: current pos/speed/dir/mode -> next pos, next dir, event.
// One instance is shared by every lane through the sweep mux.
module lane_step
    import obstacle_lane_bank_pkg::*;
#(
    parameter int unsigned POS_W   = 10,
    parameter int unsigned SPEED_W = 4,
    parameter int unsigned MIN_POS = 16,
    parameter int unsigned MAX_POS = 400
) (
    input  logic [POS_W-1:0]   pos,
    input  logic [SPEED_W-1:0] speed,
    input  logic               dir,
    input  logic               mode,
    output logic [POS_W-1:0]   next_pos,
    output logic               next_dir,
    output logic               evt
);
    // Two guard bits keep pos +/- speed free of overflow and sign ambiguity.
    localparam int unsigned NW = POS_W + 2;
    localparam logic signed [NW-1:0] LO  = NW'(MIN_POS);
    localparam logic signed [NW-1:0] HI  = NW'(MAX_POS);
    localparam logic signed [NW-1:0] ONE = NW'(1);

    logic signed [NW-1:0] p;
    logic signed [NW-1:0] s;
    logic signed [NW-1:0] n;
    logic signed [NW-1:0] r;

    // Advance one step, resolving bound crossings by bounce or wrap; clamp protects illegal speeds.
    always_comb begin
        p        = NW'(pos);
        s        = NW'(speed);
        n        = dir ? (p - s) : (p + s);
        r        = n;
        next_dir = dir;
        evt      = 1'b0;
        if (!dir && (n > HI)) begin
            evt = 1'b1;
            if (lane_mode_t'(mode) == MODE_WRAP) begin
                r = LO + (n - HI - ONE);
                if (r > HI) r = HI;
            end else begin
                r        = HI;
                next_dir = 1'b1;
            end
        end else if (dir && (n < LO)) begin
            evt = 1'b1;
            if (lane_mode_t'(mode) == MODE_WRAP) begin
                r = HI - (LO - n - ONE);
                if (r < LO) r = LO;
            end else begin
                r        = LO;
                next_dir = 1'b0;
            end
        end
        next_pos = r[POS_W-1:0];
    end

endmodule

// File: rtl/obstacle_lane_bank.sv
// Bank of independent obstacle lanes advanced one lane per cycle on each frame tick.
module obstacle_lane_bank
    import obstacle_lane_bank_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned POS_W     = 10,
    parameter int unsigned SPEED_W   = 4,
    parameter int unsigned MIN_POS   = 16,
    parameter int unsigned MAX_POS   = 400,
    localparam int unsigned LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       pause,
    input  logic                       cfg_we,
    input  logic [LANE_W-1:0]          cfg_lane,
    input  logic [POS_W-1:0]           cfg_pos,
    input  logic [SPEED_W-1:0]         cfg_speed,
    input  logic                       cfg_dir,
    input  logic                       cfg_mode,
    output logic [NUM_LANES*POS_W-1:0] pos_flat,
    output logic [NUM_LANES-1:0]       dir_flat,
    output logic [NUM_LANES-1:0]       edge_evt,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);
    localparam logic [LANE_W-1:0] LAST_IDX = LANE_W'(NUM_LANES - 1);

    logic [POS_W-1:0]   pos_q   [NUM_LANES];
    logic [SPEED_W-1:0] speed_q [NUM_LANES];
    logic               dir_q   [NUM_LANES];
    lane_mode_t         mode_q  [NUM_LANES];

    sweep_state_t      state_q, state_d;
    logic [LANE_W-1:0] idx_q, idx_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic              tick_v;
    logic              collide;

    logic [POS_W-1:0]   cur_pos;
    logic [SPEED_W-1:0] cur_speed;
    logic               cur_dir;
    lane_mode_t         cur_mode;
    logic [POS_W-1:0]   step_pos;
    logic               step_dir;
    logic               step_evt;

    // Select the lane currently being swept into the shared stepper.
    always_comb begin
        cur_pos   = pos_q[0];
        cur_speed = speed_q[0];
        cur_dir   = dir_q[0];
        cur_mode  = mode_q[0];
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (idx_q == LANE_W'(i)) begin
                cur_pos   = pos_q[i];
                cur_speed = speed_q[i];
                cur_dir   = dir_q[i];
                cur_mode  = mode_q[i];
            end
        end
    end

    lane_step #(
        .POS_W   (POS_W),
        .SPEED_W (SPEED_W),
        .MIN_POS (MIN_POS),
        .MAX_POS (MAX_POS)
    ) u_step (
        .pos      (cur_pos),
        .speed    (cur_speed),
        .dir      (cur_dir),
        .mode     (logic'(cur_mode)),
        .next_pos (step_pos),
        .next_dir (step_dir),
        .evt      (step_evt)
    );

    assign tick_v  = tick & ~pause;
    assign collide = cfg_we && (cfg_lane == idx_q);

    // Lane registers: a config write takes priority over the sweep step on the same lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                pos_q[i]   <= POS_W'(MIN_POS);
                speed_q[i] <= '0;
                dir_q[i]   <= 1'b0;
                mode_q[i]  <= MODE_BOUNCE;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (cfg_we && (cfg_lane == LANE_W'(i))) begin
                    pos_q[i]   <= POS_W'(clamp_range(32'(cfg_pos), MIN_POS, MAX_POS));
                    speed_q[i] <= cfg_speed;
                    dir_q[i]   <= cfg_dir;
                    mode_q[i]  <= lane_mode_t'(cfg_mode);
                end else if ((state_q == SWEEP) && (idx_q == LANE_W'(i))) begin
                    pos_q[i] <= step_pos;
                    dir_q[i] <= step_dir;
                end
            end
        end
    end

    // Sequencer state, lane index, pending-tick flag and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: a tick arriving on the final lane counts as pending and restarts the sweep.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (tick_v) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (tick_v && pend_q) ovr_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    pend_d = 1'b0;
                    if (!(pend_q || tick_v)) state_d = IDLE;
                end else begin
                    idx_d  = idx_q + LANE_W'(1);
                    pend_d = pend_q | tick_v;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: flattened lane state, step event (suppressed on collision), status flags.
    always_comb begin
        pos_flat = '0;
        dir_flat = '0;
        edge_evt = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            pos_flat[i*POS_W +: POS_W] = pos_q[i];
            dir_flat[i]                = dir_q[i];
            if ((state_q == SWEEP) && (idx_q == LANE_W'(i)) && step_evt && !collide)
                edge_evt[i] = 1'b1;
        end
        busy    = (state_q == SWEEP);
        done    = (state_q == SWEEP) && (idx_q == LAST_IDX);
        overrun = ovr_q;
    end

endmodule
